// File: rtl/tpu_pkg.sv
// Shared types and defaults for the TPU A-side memory loader.
package tpu_pkg;

   localparam int MEMA_BITS_AB = 8;
   localparam int MEMA_DIM     = 8;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} mema_ld_state_t;

   // Skewed columns need 3*DIM-2 enable cycles to fully drain into the array.
   function automatic int drain_cyc_default(input int dim);
      return 3 * dim - 2;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/mema_loader.sv
// Feeds DIM signed rows into the A transpose memory, then drains the skewed columns.
// Optional LOAD-stall counter output enabled by defining MEMA_STALL_CNT_EN.
module mema_loader
   import tpu_pkg::*;
#(
   parameter int BITS_AB   = MEMA_BITS_AB,
   parameter int DIM       = MEMA_DIM,
   parameter int DRAIN_CYC = drain_cyc_default(DIM)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       row_valid,
   output logic                       row_ready,
   input  logic signed [BITS_AB-1:0]  row_data [DIM],
   output logic signed [BITS_AB-1:0]  Ain [DIM],
   output logic [$clog2(DIM)-1:0]     Arow,
   output logic                       WrEn,
   output logic                       en,
   output logic                       busy,
   output logic                       done
`ifdef MEMA_STALL_CNT_EN
   ,
   output logic [15:0]                stall_cnt
`endif
);

   localparam int AW = $clog2(DIM);
   localparam int RW = AW + 1;
   localparam int CW = $clog2(DRAIN_CYC) + 1;

   mema_ld_state_t             state_q, state_d;
   logic [RW-1:0]              row_cnt_q, row_cnt_d;
   logic [CW-1:0]              cyc_cnt_q, cyc_cnt_d;
   logic signed [BITS_AB-1:0]  ain_q [DIM];
   logic signed [BITS_AB-1:0]  ain_d [DIM];
   logic [AW-1:0]              arow_q, arow_d;
   logic                       wren_q, wren_d;
   logic                       en_q, en_d;
   logic                       accept;

   assign accept = row_valid && (state_q == LOAD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         row_cnt_q <= '0;
         cyc_cnt_q <= '0;
         ain_q     <= '{default: '0};
         arow_q    <= '0;
         wren_q    <= 1'b0;
         en_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_cnt_q <= row_cnt_d;
         cyc_cnt_q <= cyc_cnt_d;
         ain_q     <= ain_d;
         arow_q    <= arow_d;
         wren_q    <= wren_d;
         en_q      <= en_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      row_cnt_d = row_cnt_q;
      cyc_cnt_d = cyc_cnt_q;
      ain_d     = ain_q;
      arow_d    = arow_q;
      wren_d    = 1'b0;
      en_d      = 1'b0;
      case (state_q)
         IDLE: begin
            cyc_cnt_d = '0;
            if (start) begin
               state_d   = LOAD;
               row_cnt_d = '0;
            end
         end
         LOAD: begin
            cyc_cnt_d = '0;
            if (accept) begin
               wren_d    = 1'b1;
               ain_d     = row_data;
               arow_d    = row_cnt_q[AW-1:0];
               row_cnt_d = row_cnt_q + RW'(1);
               if (row_cnt_q == RW'(DIM - 1)) begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            // First RUN cycle carries the last WrEn; en only rises after it.
            if (!en_q) begin
               en_d = 1'b1;
            end else if (cyc_cnt_q == CW'(DRAIN_CYC - 1)) begin
               state_d = DONE;
            end else begin
               en_d      = 1'b1;
               cyc_cnt_d = cyc_cnt_q + CW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      row_ready = (state_q == LOAD);
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
   end

   assign Ain  = ain_q;
   assign Arow = arow_q;
   assign WrEn = wren_q;
   assign en   = en_q;

`ifdef MEMA_STALL_CNT_EN
   sat_counter #(
      .WIDTH(16)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start && (state_q == IDLE)),
      .inc   ((state_q == LOAD) && !row_valid),
      .cnt   (stall_cnt)
   );
`endif

endmodule

// File: tb/tb_mema_loader.sv
// Randomized self-checking bench for mema_loader against a cycle-timeline reference model.
module tb_mema_loader;

   localparam int BITS_AB = 8;
   localparam int DIM     = 8;
   localparam int DRAIN   = 22;
   localparam int MAXC    = 160;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic                      start;
   logic                      row_valid;
   logic                      row_ready;
   logic signed [BITS_AB-1:0] row_data [DIM];
   logic signed [BITS_AB-1:0] Ain [DIM];
   logic [2:0]                Arow;
   logic                      WrEn;
   logic                      en;
   logic                      busy;
   logic                      done;
`ifdef MEMA_STALL_CNT_EN
   logic [15:0]               stall_cnt;
`endif

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   mema_loader #(
      .BITS_AB(BITS_AB),
      .DIM    (DIM)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .row_valid(row_valid),
      .row_ready(row_ready),
      .row_data (row_data),
      .Ain      (Ain),
      .Arow     (Arow),
      .WrEn     (WrEn),
      .en       (en),
      .busy     (busy),
      .done     (done)
`ifdef MEMA_STALL_CNT_EN
      ,
      .stall_cnt(stall_cnt)
`endif
   );

   function automatic logic [DIM*BITS_AB-1:0] pack_ain();
      logic [DIM*BITS_AB-1:0] v;
      for (int j = 0; j < DIM; j++) v[j*BITS_AB +: BITS_AB] = Ain[j];
      return v;
   endfunction

   task automatic test_reset();
      rst_n     = 1'b0;
      start     = 1'b0;
      row_valid = 1'b0;
      for (int j = 0; j < DIM; j++) row_data[j] = 8'($urandom);
      #12;
      n_total++;
      if ({row_ready, WrEn, en, busy, done, Arow} !== 8'h00)
         $display("FAIL reset_ctrl got=%b want=00000000", {row_ready, WrEn, en, busy, done, Arow});
      else n_pass++;
      n_total++;
      if (pack_ain() !== '0) $display("FAIL reset_ain got=%h want=0", pack_ain());
      else n_pass++;
`ifdef MEMA_STALL_CNT_EN
      n_total++;
      if (stall_cnt !== 16'd0) $display("FAIL reset_stall got=%0d want=0", stall_cnt);
      else n_pass++;
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_idle_noise();
      start = 1'b0;
      for (int c = 0; c < 10; c++) begin
         row_valid = 1'b1;
         for (int j = 0; j < DIM; j++) row_data[j] = 8'($urandom);
         @(posedge clk); #1;
         n_total++;
         if ({row_ready, WrEn, busy} !== 3'b000)
            $display("FAIL idle_noise cyc=%0d got rdy/wr/busy=%b want=000", c, {row_ready, WrEn, busy});
         else n_pass++;
      end
      row_valid = 1'b0;
   endtask

   // mode: 0 back-to-back, 1 alternating valid, 2 random valid
   // fill: 0 random, 1 row i = {i..i+7}, 2 signed extremes
   task automatic run_tile(input int mode, input bit start_in_run, input int fill, input string tag);
      logic signed [BITS_AB-1:0] rows [DIM][DIM];
      bit vin    [MAXC+1];
      bit e_rdy  [MAXC+1];
      bit e_wr   [MAXC+1];
      bit e_en   [MAXC+1];
      bit e_done [MAXC+1];
      bit e_busy [MAXC+1];
      int e_row  [MAXC+1];
      int n, last, n_drv, stop, e_stall;
      logic [DIM*BITS_AB-1:0] want;

      for (int i = 0; i < DIM; i++)
         for (int j = 0; j < DIM; j++)
            case (fill)
               1:       rows[i][j] = 8'(i + j);
               2:       rows[i][j] = ((i + j) % 2 == 1) ? 8'sh7F : 8'sh80;
               default: rows[i][j] = 8'($urandom);
            endcase

      for (int s = 0; s <= MAXC; s++) begin
         case (mode)
            0:       vin[s] = 1'b1;
            1:       vin[s] = (s % 2 == 1);
            default: vin[s] = (s > 40) ? 1'b1 : 1'($urandom_range(0, 1));
         endcase
         e_rdy[s] = 0; e_wr[s] = 0; e_en[s] = 0; e_done[s] = 0; e_busy[s] = 0; e_row[s] = 0;
      end

      // Timeline: cycle s follows the s-th edge after start is sampled.
      n = 0; last = -1; e_stall = 0;
      for (int s = 1; s <= MAXC - 30 && last < 0; s++) begin
         e_rdy[s] = 1'b1;
         if (vin[s]) begin
            e_wr[s+1]  = 1'b1;
            e_row[s+1] = n;
            n++;
            if (n == DIM) last = s;
         end else begin
            e_stall++;
         end
      end
      for (int s = last + 2; s <= last + 1 + DRAIN; s++) e_en[s] = 1'b1;
      e_done[last + DRAIN + 2] = 1'b1;
      for (int s = 1; s <= last + DRAIN + 2; s++) e_busy[s] = 1'b1;
      stop = last + DRAIN + 3;

      start     = 1'b1;
      row_valid = 1'($urandom_range(0, 1));
      for (int j = 0; j < DIM; j++) row_data[j] = 8'($urandom);
      @(posedge clk); #1;
      n_drv = 0;
      for (int s = 1; s <= stop; s++) begin
         n_total++;
         if (row_ready !== e_rdy[s]) $display("FAIL %s row_ready cyc=%0d got=%b want=%b", tag, s, row_ready, e_rdy[s]);
         else n_pass++;
         n_total++;
         if (WrEn !== e_wr[s]) $display("FAIL %s WrEn cyc=%0d got=%b want=%b", tag, s, WrEn, e_wr[s]);
         else n_pass++;
         n_total++;
         if (en !== e_en[s]) $display("FAIL %s en cyc=%0d got=%b want=%b", tag, s, en, e_en[s]);
         else n_pass++;
         n_total++;
         if (done !== e_done[s]) $display("FAIL %s done cyc=%0d got=%b want=%b", tag, s, done, e_done[s]);
         else n_pass++;
         n_total++;
         if (busy !== e_busy[s]) $display("FAIL %s busy cyc=%0d got=%b want=%b", tag, s, busy, e_busy[s]);
         else n_pass++;
         if (e_wr[s]) begin
            for (int j = 0; j < DIM; j++) want[j*BITS_AB +: BITS_AB] = rows[e_row[s]][j];
            n_total++;
            if (Arow !== 3'(e_row[s])) $display("FAIL %s Arow cyc=%0d got=%0d want=%0d", tag, s, Arow, e_row[s]);
            else n_pass++;
            n_total++;
            if (pack_ain() !== want) $display("FAIL %s Ain cyc=%0d got=%h want=%h", tag, s, pack_ain(), want);
            else n_pass++;
         end
         if (s == stop) break;
         start     = start_in_run && (s >= last + 3) && (s <= last + 12);
         row_valid = vin[s];
         for (int j = 0; j < DIM; j++)
            row_data[j] = (vin[s] && e_rdy[s] && n_drv < DIM) ? rows[n_drv][j] : 8'($urandom);
         if (vin[s] && e_rdy[s]) n_drv++;
         @(posedge clk); #1;
      end
      start = 1'b0;
`ifdef MEMA_STALL_CNT_EN
      n_total++;
      if (stall_cnt !== 16'(e_stall)) $display("FAIL %s stall_cnt got=%0d want=%0d", tag, stall_cnt, e_stall);
      else n_pass++;
`endif
   endtask

   task automatic test_back_to_back();
      run_tile(0, 1'b0, 1, "back_to_back");
   endtask

   task automatic test_bubbled();
      run_tile(1, 1'b0, 0, "bubbled");
   endtask

   task automatic test_boundary_start_in_run();
      run_tile(0, 1'b1, 0, "start_in_run");
   endtask

   task automatic test_random_valid();
      run_tile(2, 1'b0, 0, "random_valid");
      run_tile(2, 1'b1, 0, "random_valid_start");
   endtask

   task automatic test_signed_restart();
      run_tile(0, 1'b0, 2, "signed");
      run_tile(2, 1'b0, 1, "restart");
   endtask

   task automatic test_reset_mid_run();
      start     = 1'b1;
      row_valid = 1'b1;
      for (int j = 0; j < DIM; j++) row_data[j] = 8'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
      for (int s = 1; s <= DIM; s++) begin
         for (int j = 0; j < DIM; j++) row_data[j] = 8'($urandom);
         @(posedge clk); #1;
      end
      repeat (5) begin @(posedge clk); #1; end
      n_total++;
      if ({en, busy} !== 2'b11) $display("FAIL rst_run pre en/busy got=%b want=11", {en, busy});
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if ({row_ready, WrEn, en, busy, done, Arow} !== 8'h00)
         $display("FAIL rst_run ctrl got=%b want=00000000", {row_ready, WrEn, en, busy, done, Arow});
      else n_pass++;
      n_total++;
      if (pack_ain() !== '0) $display("FAIL rst_run ain got=%h want=0", pack_ain());
      else n_pass++;
      row_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         n_total++;
         if ({done, busy, en} !== 3'b000) $display("FAIL rst_run hold done/busy/en got=%b want=000", {done, busy, en});
         else n_pass++;
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_tile(0, 1'b0, 0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_idle_noise();
      test_back_to_back();
      test_bubbled();
      test_boundary_start_in_run();
      test_random_valid();
      test_signed_restart();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
